// File: rtl/shift_norm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : shift_norm
//  Purpose  : Iterative normalizer. Takes an operand and shifts it left one
//             bit per cycle until it is normalized. It then returns the
//             normalized value, the number of shifts applied and a zero flag.
//             The shift count is the amount a right shift needs to rebuild
//             the original operand:
//               - logical mode:    x == y >>  shamt
//               - arithmetic mode: x == y >>> shamt
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk        in   1   clock, rising edge
//    Rst_n      in   1   asynchronous active-low reset
//    in_valid   in   1   operand offered
//    in_ready   out  1   block can accept an operand (IDLE only)
//    x          in   W   operand, sampled on the accept edge
//    AL         in   1   0 = logical, 1 = arithmetic (signed) normalize
//    out_valid  out  1   result available
//    out_ready  in   1   consumer takes the result
//    y          out  W   normalized value
//    shamt      out  SW  number of left shifts applied
//    zero       out  1   operand was all zeros
// ============================================================================
module shift_norm #(
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x,
    input  logic          AL,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  y,
    output logic [SW-1:0] shamt,
    output logic          zero
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_q,     state_d;
    logic [W-1:0]  data_q,      data_d;
    logic [SW-1:0] cnt_q,       cnt_d;
    logic          al_q,        al_d;
    logic [W-1:0]  y_q,         y_d;
    logic [SW-1:0] shamt_q,     shamt_d;
    logic          zero_q,      zero_d;
    logic          out_valid_q, out_valid_d;

    logic          data_is_zero;
    logic          data_is_norm;

    // A zero operand can never normalize, so it is detected first.
    // Logical mode is normalized once the MSB is set. Arithmetic mode is
    // normalized once the bit under the sign differs from the sign, which
    // means one more left shift would overflow the signed value.
    assign data_is_zero = (data_q == '0);
    assign data_is_norm = al_q ? (data_q[W-1] ^ data_q[W-2]) : data_q[W-1];

    // in_ready depends only on state, so it never combinationally follows
    // in_valid or out_ready.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign shamt     = shamt_q;
    assign zero      = zero_q;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        al_d        = al_q;
        y_d         = y_q;
        shamt_d     = shamt_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = x;
                    al_d    = AL;
                    cnt_d   = '0;
                    zero_d  = 1'b0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (data_is_zero) begin
                    y_d         = '0;
                    shamt_d     = '0;
                    zero_d      = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (data_is_norm) begin
                    // The result registers are loaded only here. A reset
                    // during SHIFT therefore never exposes a partial value.
                    y_d         = data_q;
                    shamt_d     = cnt_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    data_d = {data_q[W-2:0], 1'b0};
                    cnt_d  = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            al_q        <= 1'b0;
            y_q         <= '0;
            shamt_q     <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            al_q        <= al_d;
            y_q         <= y_d;
            shamt_q     <= shamt_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
`default_nettype wire
